// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
// Defaults here set the standard core configuration.
package regfile_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int DEPTH_DEF  = 32;
    localparam int NREAD_DEF  = 2;
    localparam int NWRITE_DEF = 2;
    localparam int AW_DEF     = $clog2(DEPTH_DEF);

    typedef logic [AW_DEF-1:0] addr_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/issue bus of the register file. The issue/writeback side is the
// master and the register file is the slave.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NREAD  = NREAD_DEF,
    parameter int NWRITE = NWRITE_DEF
);
    localparam int AW = $clog2(DEPTH);

    logic [NREAD*AW-1:0]     ra;
    logic [NREAD*WIDTH-1:0]  rd;
    logic [NREAD-1:0]        rd_busy;
    logic [AW-1:0]           ra_debug;
    logic [WIDTH-1:0]        rd_debug;
    logic [NWRITE-1:0]       we;
    logic [NWRITE*AW-1:0]    wa;
    logic [NWRITE*WIDTH-1:0] wd;
    logic                    iss_we;
    logic [AW-1:0]           iss_wa;

    modport master (
        output ra, ra_debug, we, wa, wd, iss_we, iss_wa,
        input  rd, rd_busy, rd_debug
    );

    modport slave (
        input  ra, ra_debug, we, wa, wd, iss_we, iss_wa,
        output rd, rd_busy, rd_debug
    );

endinterface

// File: rtl/regfile_fwd_mux.sv
// Per-read-port forwarding mux: picks the highest-indexed write port that
// targets this read address, else the stored value. Address 0 reads as 0.
module regfile_fwd_mux
    import regfile_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NWRITE = NWRITE_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                    fwd_en_i,
    input  logic [AW-1:0]           ra_i,
    input  logic [NWRITE-1:0]       we_i,
    input  logic [NWRITE*AW-1:0]    wa_i,
    input  logic [NWRITE*WIDTH-1:0] wd_i,
    input  logic [WIDTH-1:0]        stored_i,
    output logic [WIDTH-1:0]        data_o,
    output logic                    hit_o
);

    always_comb begin
        data_o = stored_i;
        hit_o  = 1'b0;
        // Ascending scan so the highest-indexed matching port ends up selected
        for (int j = 0; j < NWRITE; j++) begin
            if (fwd_en_i && we_i[j] && (wa_i[j*AW +: AW] == ra_i)) begin
                data_o = wd_i[j*WIDTH +: WIDTH];
                hit_o  = 1'b1;
            end
        end
        if (ra_i == '0) begin
            data_o = '0;
            hit_o  = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read forwarding, an unforwarded
// debug read port and a per-register busy scoreboard for issue logic.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NREAD  = NREAD_DEF,
    parameter int NWRITE = NWRITE_DEF
) (
    input  logic         clk,
    input  logic         rstn,
    regfile_mp_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]            busy_q, busy_d;
    logic [NREAD-1:0][WIDTH-1:0] rd_data;
    logic [NREAD-1:0]            rd_hit;
    logic [NREAD-1:0]            rd_busy_w;

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int j = 0; j < NWRITE; j++) begin
            if (bus.we[j] && (bus.wa[j*AW +: AW] != '0)) begin
                mem_d[bus.wa[j*AW +: AW]]  = bus.wd[j*WIDTH +: WIDTH];
                busy_d[bus.wa[j*AW +: AW]] = 1'b0;
            end
        end
        // Issue applied after the clears: a new issue supersedes a completing write
        if (bus.iss_we && (bus.iss_wa != '0))
            busy_d[bus.iss_wa] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem_q  <= '0;
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0] ra_w;
        assign ra_w = bus.ra[i*AW +: AW];

        regfile_fwd_mux #(
            .WIDTH  (WIDTH),
            .DEPTH  (DEPTH),
            .NWRITE (NWRITE)
        ) u_fwd (
            .fwd_en_i (rstn),
            .ra_i     (ra_w),
            .we_i     (bus.we),
            .wa_i     (bus.wa),
            .wd_i     (bus.wd),
            .stored_i (mem_q[ra_w]),
            .data_o   (rd_data[i]),
            .hit_o    (rd_hit[i])
        );

        assign rd_busy_w[i] = busy_q[ra_w] & ~rd_hit[i] & (ra_w != '0);
    end

    assign bus.rd       = rd_data;
    assign bus.rd_busy  = rd_busy_w;
    // mem_q[0] is held at zero, so the debug port needs no address-0 special case
    assign bus.rd_debug = mem_q[bus.ra_debug];

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed bench for regfile_mp against an array-based model.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int WIDTH  = WIDTH_DEF;
    localparam int DEPTH  = DEPTH_DEF;
    localparam int NREAD  = NREAD_DEF;
    localparam int NWRITE = NWRITE_DEF;
    localparam int AW     = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD), .NWRITE(NWRITE)) bus ();

    regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD), .NWRITE(NWRITE)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Reference model state
    logic [WIDTH-1:0] m_mem  [DEPTH];
    bit               m_busy [DEPTH];

    // Stimulus variables
    int unsigned      t_ra  [NREAD];
    bit               t_we  [NWRITE];
    int unsigned      t_wa  [NWRITE];
    logic [WIDTH-1:0] t_wd  [NWRITE];
    bit               t_iss_we;
    int unsigned      t_iss_wa;
    int unsigned      t_ra_dbg;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        foreach (t_ra[i]) t_ra[i] = 0;
        foreach (t_we[j]) begin
            t_we[j] = 1'b0;
            t_wa[j] = 0;
            t_wd[j] = '0;
        end
        t_iss_we = 1'b0;
        t_iss_wa = 0;
        t_ra_dbg = 0;
    endtask

    task automatic apply();
        for (int i = 0; i < NREAD; i++) bus.ra[i*AW +: AW] = AW'(t_ra[i]);
        for (int j = 0; j < NWRITE; j++) begin
            bus.we[j]                = t_we[j];
            bus.wa[j*AW +: AW]       = AW'(t_wa[j]);
            bus.wd[j*WIDTH +: WIDTH] = t_wd[j];
        end
        bus.iss_we   = t_iss_we;
        bus.iss_wa   = AW'(t_iss_wa);
        bus.ra_debug = AW'(t_ra_dbg);
    endtask

    // Drive, let combinational outputs settle, compare against the model
    task automatic settle();
        logic [WIDTH-1:0] exp_d;
        bit               hit;
        apply();
        #1;
        for (int i = 0; i < NREAD; i++) begin
            exp_d = m_mem[t_ra[i]];
            hit   = 1'b0;
            if (rstn && t_ra[i] != 0)
                for (int j = NWRITE - 1; j >= 0 && !hit; j--)
                    if (t_we[j] && t_wa[j] == t_ra[i]) begin
                        exp_d = t_wd[j];
                        hit   = 1'b1;
                    end
            if (t_ra[i] == 0) exp_d = '0;
            chk($sformatf("rd%0d[r%0d]", i, t_ra[i]), 64'(bus.rd[i*WIDTH +: WIDTH]), 64'(exp_d));
            chk($sformatf("busy%0d[r%0d]", i, t_ra[i]), 64'(bus.rd_busy[i]),
                64'(m_busy[t_ra[i]] && !hit && t_ra[i] != 0));
        end
        chk($sformatf("dbg[r%0d]", t_ra_dbg), 64'(bus.rd_debug),
            64'((t_ra_dbg == 0) ? '0 : m_mem[t_ra_dbg]));
    endtask

    // Clock edge, then advance the model by the specified rules
    task automatic tick();
        @(posedge clk);
        if (!rstn) begin
            foreach (m_mem[a]) begin
                m_mem[a]  = '0;
                m_busy[a] = 1'b0;
            end
        end else begin
            for (int j = 0; j < NWRITE; j++)
                if (t_we[j] && t_wa[j] != 0) m_mem[t_wa[j]] = t_wd[j];
            for (int j = 0; j < NWRITE; j++)
                if (t_we[j] && t_wa[j] != 0) m_busy[t_wa[j]] = 1'b0;
            if (t_iss_we && t_iss_wa != 0) m_busy[t_iss_wa] = 1'b1;
        end
        @(negedge clk);
    endtask

    function automatic int unsigned rnd_addr();
        return ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 7);
    endfunction

    initial begin
        foreach (m_mem[a]) begin
            m_mem[a]  = '0;
            m_busy[a] = 1'b0;
        end
        idle();
        apply();
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Post-reset sweep of every address on every port
        for (int a = 0; a < DEPTH; a++) begin
            idle();
            t_ra[0]  = a;
            t_ra[1]  = DEPTH - 1 - a;
            t_ra_dbg = a;
            settle();
            chk("rst_rd0", 64'(bus.rd[WIDTH-1:0]), 64'd0);
            chk("rst_busy", 64'(bus.rd_busy), 64'd0);
            tick();
        end

        // Forwarding on r5; debug sees the stored value only next cycle
        idle();
        t_we[0] = 1'b1; t_wa[0] = 5; t_wd[0] = 32'hDEADBEEF;
        t_ra[0] = 5; t_ra_dbg = 5;
        settle();
        chk("fwd_r5", 64'(bus.rd[WIDTH-1:0]), 64'hDEADBEEF);
        chk("dbg_r5_old", 64'(bus.rd_debug), 64'd0);
        tick();
        idle();
        t_ra_dbg = 5;
        settle();
        chk("dbg_r5_new", 64'(bus.rd_debug), 64'hDEADBEEF);
        tick();

        // Two ports writing r7: highest port wins
        idle();
        t_we[0] = 1'b1; t_wa[0] = 7; t_wd[0] = 32'h11;
        t_we[1] = 1'b1; t_wa[1] = 7; t_wd[1] = 32'h22;
        t_ra[0] = 7;
        settle();
        chk("fwd_r7", 64'(bus.rd[WIDTH-1:0]), 64'h22);
        tick();
        idle();
        t_ra[1] = 7;
        settle();
        chk("r7_stored", 64'(bus.rd[2*WIDTH-1:WIDTH]), 64'h22);
        tick();

        // Writes to r0 are ignored
        idle();
        t_we[0] = 1'b1; t_wa[0] = 0; t_wd[0] = 32'h55;
        settle();
        chk("r0_fwd", 64'(bus.rd[WIDTH-1:0]), 64'd0);
        tick();
        idle();
        settle();
        chk("r0_dbg", 64'(bus.rd_debug), 64'd0);
        tick();

        // Issue r9, then completing write clears busy
        idle();
        t_iss_we = 1'b1; t_iss_wa = 9;
        settle();
        tick();
        idle();
        t_ra[0] = 9;
        settle();
        chk("busy_r9", 64'(bus.rd_busy[0]), 64'd1);
        tick();
        idle();
        t_we[1] = 1'b1; t_wa[1] = 9; t_wd[1] = 32'h99; t_ra[0] = 9;
        settle();
        chk("busy_r9_fwd", 64'(bus.rd_busy[0]), 64'd0);
        chk("rd_r9_fwd", 64'(bus.rd[WIDTH-1:0]), 64'h99);
        tick();
        idle();
        t_ra[0] = 9;
        settle();
        chk("busy_r9_clr", 64'(bus.rd_busy[0]), 64'd0);
        tick();

        // Issue and write same register same cycle: set wins
        idle();
        t_iss_we = 1'b1; t_iss_wa = 9;
        t_we[0] = 1'b1; t_wa[0] = 9; t_wd[0] = 32'h1234;
        settle();
        tick();
        idle();
        t_ra[0] = 9;
        settle();
        chk("setwins_busy", 64'(bus.rd_busy[0]), 64'd1);
        chk("setwins_data", 64'(bus.rd[WIDTH-1:0]), 64'h1234);
        tick();

        // Reset overrides a concurrent write; forwarding suppressed during reset
        idle();
        t_we[0] = 1'b1; t_wa[0] = 3; t_wd[0] = 32'h33;
        t_iss_we = 1'b1; t_iss_wa = 4;
        settle();
        tick();
        idle();
        rstn = 1'b0;
        t_we[0] = 1'b1; t_wa[0] = 3; t_wd[0] = 32'h44;
        t_ra[0] = 3; t_ra[1] = 4;
        settle();
        chk("rst_nofwd", 64'(bus.rd[WIDTH-1:0]), 64'h33);
        chk("rst_busy_held", 64'(bus.rd_busy[1]), 64'd1);
        tick();
        rstn = 1'b1;
        idle();
        t_ra[0] = 3; t_ra[1] = 4; t_ra_dbg = 3;
        settle();
        chk("rst_r3", 64'(bus.rd[WIDTH-1:0]), 64'd0);
        chk("rst_r4_busy", 64'(bus.rd_busy[1]), 64'd0);
        tick();

        // Randomized traffic with occasional reset
        for (int n = 0; n < 500; n++) begin
            rstn = ($urandom_range(0, 49) != 0);
            foreach (t_ra[i]) t_ra[i] = rnd_addr();
            foreach (t_we[j]) begin
                t_we[j] = ($urandom_range(0, 2) == 0);
                t_wa[j] = rnd_addr();
                t_wd[j] = $urandom;
            end
            t_iss_we = ($urandom_range(0, 2) == 0);
            t_iss_wa = rnd_addr();
            t_ra_dbg = rnd_addr();
            settle();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
